iob_fifo_wr_arb: RTL and testbench



---
 rtl/iob_fifo_wr_arb_pkg.sv | 5 +
 rtl/iob_fifo_wr_arb_rr_arb.sv | 15 +
 rtl/iob_fifo_wr_arb.sv | 87 ++++++++
 tb/tb_iob_fifo_wr_arb.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/iob_fifo_wr_arb_pkg.sv
// iob_fifo_wr_arb_pkg: FSM state encoding and default widths shared by the write arbiter
package iob_fifo_wr_arb_pkg;
  typedef enum logic {IDLE = 1'b0, BURST = 1'b1} state_e;
  localparam int LEN_W_DEF = 4;
endpackage

// File: rtl/iob_fifo_wr_arb_rr_arb.sv
// iob_rr_arb: combinational round-robin pick, first set request at or above the pointer wins
module iob_rr_arb #(
  parameter int N  = 4,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [PW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o
);
  always_comb begin
    gnt_o = '0;
    for (int k = N - 1; k >= 0; k--)
      if (req_i[(int'(ptr_i) + k) % N]) gnt_o = N'(1) << ((int'(ptr_i) + k) % N);
  end
endmodule

// File: rtl/iob_fifo_wr_arb.sv
// iob_fifo_wr_arb: round-robin burst arbiter feeding one FIFO write port
// A requester only wins when its whole burst fits in the FIFO free space.
module iob_fifo_wr_arb
  import iob_fifo_wr_arb_pkg::*;
#(
  parameter int N_REQ  = 4,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 8,
  parameter int LEN_W  = LEN_W_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ*LEN_W-1:0]  req_len,
  input  logic [N_REQ*DATA_W-1:0] req_data,
  input  logic [N_REQ-1:0]        req_valid,
  output logic [N_REQ-1:0]        gnt,
  output logic [N_REQ-1:0]        req_ready,
  output logic                    busy,
  output logic [DATA_W-1:0]       fifo_data_in,
  output logic                    fifo_write_en,
  input  logic                    fifo_full,
  input  logic [ADDR_W-1:0]       fifo_level_w
);
  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CW = (LEN_W > ADDR_W + 1) ? LEN_W : ADDR_W + 1;
  state_e             state_d, state_q;
  logic [N_REQ-1:0]   gnt_d, gnt_q, elig, win;
  logic [LEN_W-1:0]   cnt_d, cnt_q, wlen;
  logic [PW-1:0]      g_d, g_q, rr_d, rr_q, widx;
  logic [ADDR_W:0]    free;
  assign free = {1'b0, {ADDR_W{1'b1}}} - {1'b0, fifo_level_w};
  always_comb begin
    for (int i = 0; i < N_REQ; i++)
      elig[i] = req[i] && (req_len[i*LEN_W +: LEN_W] != '0) &&
                (CW'(req_len[i*LEN_W +: LEN_W]) <= CW'(free));
  end
  iob_rr_arb #(.N(N_REQ), .PW(PW)) u_rr (.req_i(elig), .ptr_i(rr_q), .gnt_o(win));
  always_comb begin
    widx = '0;
    for (int i = 0; i < N_REQ; i++) if (win[i]) widx = PW'(i);
  end
  assign wlen = req_len[widx*LEN_W +: LEN_W];
  // outputs are forced low during the reset cycle itself so an aborted burst writes nothing
  assign busy          = rst && (state_q == BURST);
  assign req_ready     = (busy && cnt_q != '0 && !fifo_full) ? gnt_q : '0;
  assign fifo_write_en = |(req_valid & req_ready);
  assign fifo_data_in  = req_data[g_q*DATA_W +: DATA_W];
  assign gnt           = gnt_q;
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    cnt_d   = cnt_q;
    g_d     = g_q;
    rr_d    = rr_q;
    if (state_q == IDLE) begin
      if (|elig) begin
        state_d = BURST;
        gnt_d   = win;
        cnt_d   = wlen;
        g_d     = widx;
      end
    end else if (fifo_write_en) begin
      cnt_d = cnt_q - 1'b1;
      if (cnt_q == LEN_W'(1)) begin
        state_d = IDLE;
        gnt_d   = '0;
        rr_d    = (g_q == PW'(N_REQ - 1)) ? '0 : g_q + 1'b1;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      cnt_q   <= '0;
      g_q     <= '0;
      rr_q    <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      cnt_q   <= cnt_d;
      g_q     <= g_d;
      rr_q    <= rr_d;
    end
  end
endmodule

// File: tb/tb_iob_fifo_wr_arb.sv
// tb_iob_fifo_wr_arb: directed stimulus with a write scoreboard checked by a separate monitor
module tb_iob_fifo_wr_arb;
  logic         clk = 0;
  logic         rst;
  logic [3:0]   req, req_valid, gnt, req_ready;
  logic [15:0]  req_len;
  logic [127:0] req_data;
  logic         busy, fifo_write_en, fifo_full;
  logic [31:0]  fifo_data_in;
  logic [7:0]   fifo_level_w;
  logic [15:0]  beat [4];
  logic [35:0]  sb [$];
  int           exp_beat [4];
  int           n_tests = 0, n_fail = 0, n_wr = 0;

  iob_fifo_wr_arb dut (
    .clk(clk), .rst(rst), .req(req), .req_len(req_len), .req_data(req_data),
    .req_valid(req_valid), .gnt(gnt), .req_ready(req_ready), .busy(busy),
    .fifo_data_in(fifo_data_in), .fifo_write_en(fifo_write_en),
    .fifo_full(fifo_full), .fifo_level_w(fifo_level_w)
  );

  always #5 clk = ~clk;

  initial for (int i = 0; i < 4; i++) beat[i] = '0;
  always @(posedge clk)
    for (int i = 0; i < 4; i++) if (req_ready[i] && req_valid[i]) beat[i] <= beat[i] + 16'd1;
  always_comb
    for (int i = 0; i < 4; i++) req_data[i*32 +: 32] = {16'(i), beat[i]};

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic push(input int r, input int n);
    for (int k = 0; k < n; k++) begin
      sb.push_back({4'(1 << r), 16'(r), 16'(exp_beat[r])});
      exp_beat[r]++;
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int k = 0;
    while (busy && k < 50) begin
      cyc(1);
      k++;
    end
    chk("idle_timeout", 64'(busy), 0);
  endtask

  task automatic do_reset();
    rst = 0;
    cyc(1);
    rst = 1;
  endtask

  always @(negedge clk) begin
    if (fifo_write_en) begin
      n_wr++;
      if (sb.size() == 0) chk("unexpected_write", 64'(fifo_data_in), 64'hdead);
      else begin
        logic [35:0] e;
        e = sb.pop_front();
        chk("sb_data", 64'(fifo_data_in), 64'(e[31:0]));
        chk("sb_gnt", 64'(gnt), 64'(e[35:32]));
      end
    end
  end

  initial begin
    int nb, nw, ng, gap, w0;
    logic [3:0] prev;
    logic [3:0] order [5];
    order[0] = 4'b0001; order[1] = 4'b0010; order[2] = 4'b0100;
    order[3] = 4'b1000; order[4] = 4'b0001;
    for (int i = 0; i < 4; i++) exp_beat[i] = 0;
    rst = 0; req = 0; req_len = 0; req_valid = 4'hf; fifo_full = 0; fifo_level_w = 0;
    cyc(2);
    chk("rst_gnt", 64'(gnt), 0);
    chk("rst_busy", 64'(busy), 0);
    chk("rst_ready", 64'(req_ready), 0);
    chk("rst_wen", 64'(fifo_write_en), 0);
    rst = 1;
    cyc(1);
    // single requester, len 4
    req_len[3:0] = 4; req = 4'b0001; push(0, 4);
    cyc(1);
    chk("t1_gnt", 64'(gnt), 4'b0001);
    req = 0; nb = 0; nw = 0;
    for (int k = 0; k < 20; k++) begin
      nb += int'(busy);
      nw += int'(fifo_write_en);
      cyc(1);
    end
    chk("t1_busy_cycles", 64'(nb), 4);
    chk("t1_writes", 64'(nw), 4);
    chk("t1_gnt_end", 64'(gnt), 0);
    // all four requesting, len 2, round-robin order from a fresh pointer
    do_reset();
    req_len = 16'h2222; req = 4'hf;
    push(0, 2); push(1, 2); push(2, 2); push(3, 2); push(0, 2);
    ng = 0; gap = 0; prev = 0;
    for (int k = 0; k < 60 && ng < 5; k++) begin
      if (gnt != 0 && prev == 0) begin
        chk("t2_order", 64'(gnt), 64'(order[ng]));
        if (ng > 0) chk("t2_idle_gap", 64'(gap), 1);
        ng++;
        gap = 0;
        if (ng == 5) req = 0;
      end else if (gnt == 0) gap++;
      prev = gnt;
      cyc(1);
    end
    chk("t2_grants", 64'(ng), 5);
    wait_idle();
    // free space gating: only requester 1 fits until the FIFO drains
    do_reset();
    fifo_level_w = 8'd252; req_len = 16'h0035; req = 4'b0011;
    push(1, 3);
    cyc(1);
    chk("t3_gnt1", 64'(gnt), 4'b0010);
    req = 4'b0001;
    wait_idle();
    cyc(3);
    chk("t3_r0_waits", 64'(gnt), 0);
    fifo_level_w = 0; push(0, 5);
    cyc(1);
    chk("t3_gnt0", 64'(gnt), 4'b0001);
    req = 0;
    wait_idle();
    // fifo_full stall for two cycles mid-burst
    w0 = n_wr;
    req_len = 16'h0600; req = 4'b0100; push(2, 6);
    cyc(1);
    chk("t4_gnt", 64'(gnt), 4'b0100);
    req = 0;
    cyc(2);
    fifo_full = 1; #1;
    chk("t4_ready_full0", 64'(req_ready), 0);
    chk("t4_wen_full0", 64'(fifo_write_en), 0);
    cyc(1);
    chk("t4_ready_full1", 64'(req_ready), 0);
    fifo_full = 0; #1;
    chk("t4_ready_resume", 64'(req_ready), 4'b0100);
    wait_idle();
    chk("t4_writes", 64'(n_wr - w0), 6);
    // valid gaps, len 3
    w0 = n_wr;
    req_len = 16'h3000; req = 4'b1000; push(3, 3);
    cyc(1);
    chk("t5_gnt", 64'(gnt), 4'b1000);
    req = 0; req_valid = 4'b0111;
    cyc(1);
    req_valid = 4'hf;
    cyc(1);
    req_valid = 4'b0111;
    cyc(2);
    chk("t5_busy_gap", 64'(busy), 1);
    chk("t5_ready_gap", 64'(req_ready), 4'b1000);
    req_valid = 4'hf;
    wait_idle();
    chk("t5_writes", 64'(n_wr - w0), 3);
    // reset after first beat of a len-8 burst
    w0 = n_wr;
    req_len = 16'h0008; req = 4'b0001; push(0, 1);
    cyc(1);
    chk("t6_gnt", 64'(gnt), 4'b0001);
    req = 0;
    cyc(1);
    rst = 0; #1;
    chk("t6_wen_rst", 64'(fifo_write_en), 0);
    cyc(1);
    chk("t6_gnt_cleared", 64'(gnt), 0);
    chk("t6_busy_cleared", 64'(busy), 0);
    rst = 1;
    cyc(3);
    chk("t6_writes", 64'(n_wr - w0), 1);
    chk("sb_empty", 64'(sb.size()), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule
